// File: rtl/player_input_decoder_pkg.sv
// Shared player-control definitions: action indices, keycode width and default key maps.
package player_input_decoder_pkg;

    localparam int unsigned KEY_W       = 8;
    localparam int unsigned NUM_ACTIONS = 8;

    localparam int unsigned ACT_UP      = 7;
    localparam int unsigned ACT_DOWN    = 6;
    localparam int unsigned ACT_LEFT    = 5;
    localparam int unsigned ACT_RIGHT   = 4;
    localparam int unsigned ACT_AIM_L   = 3;
    localparam int unsigned ACT_AIM_R   = 2;
    localparam int unsigned ACT_FIRE    = 1;
    localparam int unsigned ACT_SPECIAL = 0;

    // HID usage codes, action 7 in the top byte: W S A D Q E Space F
    localparam logic [NUM_ACTIONS*KEY_W-1:0] P1_CONTROLS =
        {8'h1A, 8'h16, 8'h04, 8'h07, 8'h14, 8'h08, 8'h2C, 8'h09};

    // Arrows, comma, period, Enter, slash
    localparam logic [NUM_ACTIONS*KEY_W-1:0] P2_CONTROLS =
        {8'h52, 8'h51, 8'h50, 8'h4F, 8'h36, 8'h37, 8'h28, 8'h38};

endpackage

// File: rtl/player_input_decoder_frame_edge_sync.sv
// Two-flop synchronizer and rising-edge detector for the VGA vertical sync.
// All flops reset high so a level already high at reset release is not an edge.
module frame_edge_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic i_async,
    output logic o_tick
);

    logic r_sync1;
    logic r_sync2;
    logic r_hist;
    logic r_tick;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_hist  <= 1'b1;
            r_tick  <= 1'b0;
        end else begin
            r_sync1 <= i_async;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
            r_tick  <= r_sync2 & ~r_hist;
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/player_input_decoder.sv
// Maps the two-slot HID keycode word onto per-player actions and produces
// frame-aligned held levels, new-press pulses and auto-repeat pulses.
module player_input_decoder
    import player_input_decoder_pkg::*;
#(
    parameter int unsigned REPEAT_DELAY  = 12,
    parameter int unsigned REPEAT_PERIOD = 4
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           frame_clk,
    input  logic [2*KEY_W-1:0]             keycode,
    input  logic [NUM_ACTIONS*KEY_W-1:0]   controls,
    input  logic                           enable,
    output logic                           frame_tick,
    output logic [NUM_ACTIONS-1:0]         held,
    output logic [NUM_ACTIONS-1:0]         press,
    output logic [NUM_ACTIONS-1:0]         repeat_fire
);

    localparam int unsigned CNT_W = 6;
    localparam logic [CNT_W-1:0] CNT_DELAY  = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(REPEAT_DELAY - REPEAT_PERIOD + 1);

    logic                   w_tick;
    logic [2*KEY_W-1:0]     r_keycode;
    logic [NUM_ACTIONS-1:0] w_raw;
    logic [NUM_ACTIONS-1:0] r_held;
    logic [NUM_ACTIONS-1:0] r_press;

    frame_edge_sync u_frame_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_async (frame_clk),
        .o_tick  (w_tick)
    );

    for (genvar i = 0; i < NUM_ACTIONS; i++) begin : g_act
        logic [KEY_W-1:0] w_slot;
        logic [CNT_W-1:0] r_cnt;
        logic             r_fire;

        assign w_slot   = controls[KEY_W*i +: KEY_W];
        // An empty map slot must not match the empty keycode slot
        assign w_raw[i] = enable & (w_slot != '0) &
                          ((r_keycode[2*KEY_W-1:KEY_W] == w_slot) |
                           (r_keycode[KEY_W-1:0] == w_slot));

        // Counter saturates at the delay and reloads so the period repeats
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_cnt  <= '0;
                r_fire <= 1'b0;
            end else begin
                r_fire <= 1'b0;
                if (w_tick) begin
                    if (!w_raw[i]) begin
                        r_cnt <= '0;
                    end else if (r_cnt == '0) begin
                        r_cnt  <= CNT_W'(1);
                        r_fire <= 1'b1;
                    end else if (r_cnt == CNT_DELAY) begin
                        r_cnt  <= CNT_RELOAD;
                        r_fire <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
            end
        end

        assign repeat_fire[i] = r_fire;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_keycode <= '0;
            r_held    <= '0;
            r_press   <= '0;
        end else begin
            r_keycode <= keycode;
            r_press   <= '0;
            if (w_tick) begin
                r_held  <= w_raw;
                r_press <= w_raw & ~r_held;
            end
        end
    end

    assign frame_tick = w_tick;
    assign held       = r_held;
    assign press      = r_press;

endmodule
